// File: rtl/rmii_tx.sv
// RMII transmit framer: wraps a byte stream in preamble/SFD, optional zero pad and a
// CRC-32 FCS, sending one dibit per 50 MHz clock, then holds off for the inter-frame gap.
`timescale 1ns/1ps
module rmii_tx #(
    parameter int IFG_BYTES = 12,
    parameter bit PAD_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [1:0] tx_d,
    output logic       tx_e,
    output logic       busy,
    output logic       underrun
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        PAD,
        FCS,
        IFG
    } state_t;

    localparam int               IFG_CYC   = (IFG_BYTES > 0) ? 4 * IFG_BYTES : 1;
    localparam int               IFG_W     = $clog2(IFG_CYC + 1);
    localparam logic [IFG_W-1:0] IFG_LAST  = IFG_W'(IFG_CYC - 1);
    localparam logic [IFG_W-1:0] IFG_ONE   = IFG_W'(1);
    localparam logic [10:0]      MIN_BYTES = 11'd60;
    localparam logic [10:0]      CNT_MAX   = 11'h7FF;
    localparam logic [31:0]      CRC_POLY  = 32'hEDB88320;
    localparam logic [31:0]      CRC_INIT  = 32'hFFFFFFFF;
    localparam logic [7:0]       PRE_BYTE  = 8'h55;
    localparam logic [7:0]       SFD_BYTE  = 8'hD5;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ d[i]) ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

    function automatic logic [1:0] dibit_of(input logic [7:0] b, input logic [1:0] idx);
        logic [1:0] d;
        case (idx)
            2'd0:    d = b[1:0];
            2'd1:    d = b[3:2];
            2'd2:    d = b[5:4];
            default: d = b[7:6];
        endcase
        return d;
    endfunction

    state_t           r_state;
    logic [1:0]       r_dib;
    logic [10:0]      r_cnt;
    logic [7:0]       r_byte;
    logic             r_last;
    logic [31:0]      r_crc;
    logic [IFG_W-1:0] r_ifg;
    logic [1:0]       r_tx_d;
    logic             r_tx_e;
    logic             r_underrun;

    state_t           w_state;
    logic [1:0]       w_dib;
    logic [10:0]      w_cnt;
    logic [7:0]       w_byte;
    logic             w_last;
    logic [31:0]      w_crc;
    logic [IFG_W-1:0] w_ifg;
    logic             w_underrun;
    logic             w_tx_e;
    logic [1:0]       w_tx_d;
    logic [10:0]      w_cnt_inc;
    logic [7:0]       w_fcs_next;
    logic             w_sfd_end;
    logic             w_byte_end;

    assign w_sfd_end  = (r_state == PREAMBLE) && (r_cnt == 11'd7) && (r_dib == 2'd3);
    assign w_byte_end = (r_dib == 2'd3);
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 11'd1;

    assign s_ready  = w_sfd_end || ((r_state == DATA) && w_byte_end && !r_last);
    assign tx_d     = r_tx_d;
    assign tx_e     = r_tx_e;
    assign busy     = (r_state != IDLE);
    assign underrun = r_underrun;

    // FCS goes out low byte first; r_cnt indexes the byte currently on the wire.
    always_comb begin
        case (r_cnt[1:0])
            2'd0:    w_fcs_next = ~r_crc[15:8];
            2'd1:    w_fcs_next = ~r_crc[23:16];
            2'd2:    w_fcs_next = ~r_crc[31:24];
            default: w_fcs_next = ~r_crc[7:0];
        endcase
    end

    // NOTE: every w_* is given a default before the case so no latch is inferred.
    always_comb begin
        w_state    = r_state;
        w_dib      = r_dib + 2'd1;
        w_cnt      = r_cnt;
        w_byte     = r_byte;
        w_last     = r_last;
        w_crc      = r_crc;
        w_ifg      = '0;
        w_underrun = 1'b0;

        case (r_state)
            IDLE: begin
                w_dib = 2'd0;
                if (s_valid) begin
                    w_state = PREAMBLE;
                    w_cnt   = 11'd0;
                    w_byte  = PRE_BYTE;
                end
            end

            PREAMBLE: begin
                if (w_sfd_end) begin
                    if (s_valid) begin
                        w_state = DATA;
                        w_byte  = s_data;
                        w_last  = s_last;
                        w_cnt   = 11'd1;
                        w_crc   = crc_byte(CRC_INIT, s_data);
                    end else begin
                        w_state    = IFG;
                        w_underrun = 1'b1;
                    end
                end else if (w_byte_end) begin
                    w_cnt  = r_cnt + 11'd1;
                    w_byte = (r_cnt == 11'd6) ? SFD_BYTE : PRE_BYTE;
                end
            end

            DATA: begin
                if (w_byte_end) begin
                    if (!r_last) begin
                        if (s_valid) begin
                            w_byte = s_data;
                            w_last = s_last;
                            w_cnt  = w_cnt_inc;
                            w_crc  = crc_byte(r_crc, s_data);
                        end else begin
                            w_state    = IFG;
                            w_underrun = 1'b1;
                        end
                    end else if (PAD_EN && (r_cnt < MIN_BYTES)) begin
                        w_state = PAD;
                        w_byte  = 8'h00;
                        w_cnt   = w_cnt_inc;
                        w_crc   = crc_byte(r_crc, 8'h00);
                    end else begin
                        w_state = FCS;
                        w_cnt   = 11'd0;
                        w_byte  = ~r_crc[7:0];
                    end
                end
            end

            PAD: begin
                if (w_byte_end) begin
                    if (r_cnt < MIN_BYTES) begin
                        w_byte = 8'h00;
                        w_cnt  = w_cnt_inc;
                        w_crc  = crc_byte(r_crc, 8'h00);
                    end else begin
                        w_state = FCS;
                        w_cnt   = 11'd0;
                        w_byte  = ~r_crc[7:0];
                    end
                end
            end

            FCS: begin
                if (w_byte_end) begin
                    if (r_cnt[1:0] == 2'd3) begin
                        w_state = IFG;
                    end else begin
                        w_cnt  = r_cnt + 11'd1;
                        w_byte = w_fcs_next;
                    end
                end
            end

            IFG: begin
                w_dib = 2'd0;
                if (r_ifg == IFG_LAST) begin
                    // A frame already waiting starts straight out of the gap, so a
                    // held s_valid sees exactly the gap length with busy kept high.
                    if (s_valid) begin
                        w_state = PREAMBLE;
                        w_cnt   = 11'd0;
                        w_byte  = PRE_BYTE;
                    end else begin
                        w_state = IDLE;
                    end
                end else begin
                    w_ifg = r_ifg + IFG_ONE;
                end
            end

            default: begin
                w_state = IDLE;
                w_dib   = 2'd0;
            end
        endcase
    end

    // Line outputs are computed from the next state so they register in step with it.
    assign w_tx_e = (w_state == PREAMBLE) || (w_state == DATA) ||
                    (w_state == PAD)      || (w_state == FCS);
    assign w_tx_d = w_tx_e ? dibit_of(w_byte, w_dib) : 2'b00;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dib      <= 2'd0;
            r_cnt      <= 11'd0;
            r_byte     <= 8'h00;
            r_last     <= 1'b0;
            r_crc      <= 32'h0;
            r_ifg      <= '0;
            r_tx_d     <= 2'b00;
            r_tx_e     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_dib      <= w_dib;
            r_cnt      <= w_cnt;
            r_byte     <= w_byte;
            r_last     <= w_last;
            r_crc      <= w_crc;
            r_ifg      <= w_ifg;
            r_tx_d     <= w_tx_d;
            r_tx_e     <= w_tx_e;
            r_underrun <= w_underrun;
        end
    end

endmodule

// File: tb/tb_rmii_tx.sv
// Directed bench for rmii_tx: one padding and one non-padding instance share the stimulus;
// a line monitor reassembles wire bytes and the checks compare against a CRC-32 model.
`timescale 1ns/1ps
module tb_rmii_tx;

    typedef logic [7:0] bq_t[$];

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       sel     = 1'b1;
    logic [7:0] s_data  = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last  = 1'b0;

    logic       valid_p, valid_n;
    logic       rdy_p, rdy_n, e_p, e_n, busy_p, busy_n, und_p, und_n;
    logic [1:0] d_p, d_n;
    logic       m_rdy, m_e, m_busy, m_und;
    logic [1:0] m_d;

    assign valid_p = s_valid & ~sel;
    assign valid_n = s_valid & sel;
    assign m_rdy   = sel ? rdy_n  : rdy_p;
    assign m_e     = sel ? e_n    : e_p;
    assign m_d     = sel ? d_n    : d_p;
    assign m_busy  = sel ? busy_n : busy_p;
    assign m_und   = sel ? und_n  : und_p;

    rmii_tx #(.IFG_BYTES(12), .PAD_EN(1'b1)) u_pad (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(valid_p), .s_last(s_last),
        .s_ready(rdy_p), .tx_d(d_p), .tx_e(e_p), .busy(busy_p), .underrun(und_p)
    );

    rmii_tx #(.IFG_BYTES(12), .PAD_EN(1'b0)) u_nopad (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(valid_n), .s_last(s_last),
        .s_ready(rdy_n), .tx_d(d_n), .tx_e(e_n), .busy(busy_n), .underrun(und_n)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Line monitor state (written only by the monitor process).
    bq_t        wire_q;
    int         fstart_q[$];
    int         txe_cnt = 0, und_cnt = 0, rdy_cnt = 0, hs_cnt = 0;
    int         low_run = 0, ifg_busy = 0, gap_last = 0, gap_busy_last = 0, rise_cnt = 0;
    int         k = 0;
    logic       prev_e = 1'b0;
    logic [7:0] acc = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (m_e) begin
                if (!prev_e) begin
                    k = 0;
                    rise_cnt++;
                    gap_last = low_run;
                    gap_busy_last = ifg_busy;
                    fstart_q.push_back(wire_q.size());
                end
                acc[2*k +: 2] = m_d;
                if (k == 3) begin
                    wire_q.push_back(acc);
                    k = 0;
                end else begin
                    k++;
                end
                txe_cnt++;
                low_run = 0;
                ifg_busy = 0;
            end else begin
                low_run++;
                if (m_busy) ifg_busy++;
            end
            if (m_und) und_cnt++;
            if (m_rdy) rdy_cnt++;
            if (m_rdy && s_valid) hs_cnt++;
            prev_e = m_e;
        end
    end

    // Stimulus stream and snapshots of the monitor counters.
    bq_t  pay_q;
    logic last_q[$];
    int   b_txe, b_und, b_rdy, b_hs, b_wire, b_rise;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_txe  = txe_cnt;
        b_und  = und_cnt;
        b_rdy  = rdy_cnt;
        b_hs   = hs_cnt;
        b_wire = wire_q.size();
        b_rise = rise_cnt;
    endtask

    task automatic add_frame(input bq_t pl, input bit with_last);
        for (int i = 0; i < pl.size(); i++) begin
            pay_q.push_back(pl[i]);
            last_q.push_back(with_last && (i == pl.size() - 1));
        end
    endtask

    function automatic logic [31:0] crc_ref(input bq_t q);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Presents pay_q after gap idle cycles; advances on each sampled s_ready.
    task automatic run_stream(input int gap);
        int   i;
        int   n;
        int   guard;
        logic hs;
        n = pay_q.size();
        i = 0;
        guard = 0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_data  = pay_q[0];
        s_last  = last_q[0];
        while (i < n && guard < 20000) begin
            @(negedge clk);
            guard++;
            hs = m_rdy;
            @(posedge clk);
            #1;
            if (hs) begin
                i++;
                if (i < n) begin
                    s_data = pay_q[i];
                    s_last = last_q[i];
                end else begin
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                    s_data  = 8'h00;
                end
            end
        end
        check("stream bytes accepted", i, n);
        pay_q.delete();
        last_q.delete();
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (m_busy && g < 20000);
        check("returned to idle", m_busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic verify(input string tag, input bq_t pl, input int start, input int nwire,
                          input bit pad);
        bq_t         fr;
        logic [31:0] fcs;
        logic [31:0] got_fcs;
        logic [7:0]  e;
        int          nexp;
        int          nbad;
        fr = pl;
        if (pad) while (fr.size() < 60) fr.push_back(8'h00);
        fcs  = ~crc_ref(fr);
        nexp = fr.size() + 12;
        check({tag, " wire length"}, nwire, nexp);
        nbad = 0;
        for (int j = 0; j < nexp && j < nwire; j++) begin
            if (j < 7) e = 8'h55;
            else if (j == 7) e = 8'hD5;
            else if (j < 8 + fr.size()) e = fr[j-8];
            else e = fcs[8*(j-8-fr.size()) +: 8];
            if (wire_q[start+j] !== e) nbad++;
        end
        check({tag, " bad wire bytes"}, nbad, 0);
        if (nwire >= nexp) begin
            got_fcs = {wire_q[start+nexp-1], wire_q[start+nexp-2],
                       wire_q[start+nexp-3], wire_q[start+nexp-4]};
            check({tag, " fcs"}, got_fcs, fcs);
        end
    endtask

    initial begin
        bq_t pl;
        bq_t pl_b;
        int  s1, s2, g, len;

        // Reset with s_valid already high on the non-padding instance.
        sel = 1'b1;
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = 8'h31;
        repeat (3) @(posedge clk);
        #1;
        check("reset tx_e", m_e, 1'b0);
        check("reset tx_d", m_d, 2'b00);
        check("reset busy", m_busy, 1'b0);
        check("reset s_ready", m_rdy, 1'b0);
        check("reset underrun", m_und, 1'b0);
        snap();
        rst = 1'b0;
        @(negedge clk);
        check("no start before first free edge", m_e, 1'b0);
        @(posedge clk);
        #1;
        check("preamble starts after edge", m_e, 1'b1);
        check("first preamble dibit", m_d, 2'b01);
        check("busy at frame start", m_busy, 1'b1);

        // "123456789" without padding.
        pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        add_frame(pl, 1'b1);
        run_stream(0);
        wait_idle();
        verify("ascii", pl, b_wire, wire_q.size() - b_wire, 1'b0);
        if (wire_q.size() >= b_wire + 21)
            check("ascii fcs bytes on wire",
                  {wire_q[b_wire+17], wire_q[b_wire+18], wire_q[b_wire+19], wire_q[b_wire+20]},
                  32'h2639F4CB);
        check("ascii tx_e cycles", txe_cnt - b_txe, 84);
        check("ascii handshakes", hs_cnt - b_hs, 9);
        check("ascii no underrun", und_cnt - b_und, 0);
        check("ascii ifg cycles", ifg_busy, 48);

        // Single byte, padded to 60.
        sel = 1'b0;
        snap();
        pl = {8'hAB};
        add_frame(pl, 1'b1);
        run_stream(3);
        wait_idle();
        verify("one byte", pl, b_wire, wire_q.size() - b_wire, 1'b1);
        check("one byte tx_e cycles", txe_cnt - b_txe, 288);
        check("one byte handshakes", hs_cnt - b_hs, 1);
        check("one byte s_ready cycles", rdy_cnt - b_rdy, 1);

        // Two 64-byte frames back to back with s_valid held high.
        snap();
        pl.delete();
        pl_b.delete();
        for (int i = 0; i < 64; i++) begin
            pl.push_back(8'(i * 3 + 1));
            pl_b.push_back(8'(8'hFF - i));
        end
        add_frame(pl, 1'b1);
        add_frame(pl_b, 1'b1);
        run_stream(0);
        wait_idle();
        s1 = b_wire;
        s2 = fstart_q[$];
        verify("b2b first", pl, s1, s2 - s1, 1'b1);
        verify("b2b second", pl_b, s2, wire_q.size() - s2, 1'b1);
        check("b2b frame starts", rise_cnt - b_rise, 2);
        check("b2b gap tx_e low", gap_last, 48);
        check("b2b gap busy high", gap_busy_last, 48);
        check("b2b tx_e cycles", txe_cnt - b_txe, 608);

        // Underrun after 10 accepted bytes.
        snap();
        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back(8'(8'h10 + i));
        add_frame(pl, 1'b0);
        run_stream(1);
        wait_idle();
        check("underrun pulses", und_cnt - b_und, 1);
        check("underrun tx_e cycles", txe_cnt - b_txe, 72);
        check("underrun wire bytes", wire_q.size() - b_wire, 18);
        if (wire_q.size() >= b_wire + 18)
            check("underrun last byte", wire_q[b_wire+17], 8'h19);
        check("underrun handshakes", hs_cnt - b_hs, 10);
        check("underrun ifg cycles", ifg_busy, 48);

        // Reset during the 5th FCS cycle of a 60-byte frame.
        snap();
        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'(i) ^ 8'h5A);
        add_frame(pl, 1'b1);
        run_stream(0);
        g = 0;
        do begin
            @(posedge clk);
            #1;
            g++;
        end while ((txe_cnt - b_txe) < 276 && g < 2000);
        check("reached 5th fcs cycle", txe_cnt - b_txe, 276);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid-fcs reset tx_e", m_e, 1'b0);
        check("mid-fcs reset tx_d", m_d, 2'b00);
        check("mid-fcs reset busy", m_busy, 1'b0);
        check("mid-fcs reset s_ready", m_rdy, 1'b0);
        check("mid-fcs reset underrun", m_und, 1'b0);
        rst = 1'b0;
        snap();
        pl = {8'hC1, 8'hC2, 8'hC3};
        add_frame(pl, 1'b1);
        run_stream(2);
        wait_idle();
        verify("after reset", pl, b_wire, wire_q.size() - b_wire, 1'b1);
        check("after reset tx_e cycles", txe_cnt - b_txe, 288);

        // Random lengths and contents with a random idle gap before the frame.
        for (int r = 0; r < 2; r++) begin
            snap();
            pl.delete();
            len = $urandom_range(60, 1500);
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
            add_frame(pl, 1'b1);
            run_stream($urandom_range(0, 25));
            wait_idle();
            verify("random", pl, b_wire, wire_q.size() - b_wire, 1'b1);
            check("random no underrun", und_cnt - b_und, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
